// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared constants and types for the arrow spawn scheduler
// Purpose: lane encodings, ring geometry, arrow start coordinate and FSM state type.
// Ports: none (package).
package ddr_pkg;

    localparam logic [1:0] LANE_U = 2'd0;
    localparam logic [1:0] LANE_D = 2'd1;
    localparam logic [1:0] LANE_R = 2'd2;
    localparam logic [1:0] LANE_L = 2'd3;

    localparam int MAX_ARROWS = 10;
    localparam int SLOT_W     = 4;
    localparam int COORD_W    = 11;

    // Starting y coordinate loaded into a freshly spawned arrow slot.
    localparam logic [COORD_W-1:0] U_BOUND = 11'd40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PICK  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    // Lane rotation is plain modulo-4 addition on the 2-bit encoding.
    function automatic logic [1:0] lane_add(input logic [1:0] a, input logic [1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/arrow_spawn_scheduler_lane_tracker.sv
// rtl/arrow_spawn_scheduler_lane_tracker.sv - per-lane ring occupancy and pointers
// Purpose: tracks occupancy, write and read pointers of one lane's arrow ring.
// Ports: clk, reset (async, active-high), spawn_en (slot taken), retire_en (oldest
//        arrow left), occ (live arrows), wptr (next slot to load), rptr (oldest slot),
//        full (occ == MAX_ARROWS).
module lane_tracker #(
    parameter int MAX_ARROWS = ddr_pkg::MAX_ARROWS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       spawn_en,
    input  logic                       retire_en,
    output logic [ddr_pkg::SLOT_W-1:0] occ,
    output logic [ddr_pkg::SLOT_W-1:0] wptr,
    output logic [ddr_pkg::SLOT_W-1:0] rptr,
    output logic                       full
);
    import ddr_pkg::*;

    localparam logic [SLOT_W-1:0] CAP  = SLOT_W'(MAX_ARROWS);
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(MAX_ARROWS - 1);

    logic [SLOT_W-1:0] occ_q, occ_d;
    logic [SLOT_W-1:0] wptr_q, wptr_d;
    logic [SLOT_W-1:0] rptr_q, rptr_d;
    logic              do_retire;

    always_comb begin
        // A retire on an empty lane is dropped so the count cannot underflow.
        do_retire = retire_en && (occ_q != '0);
        occ_d     = occ_q;
        case ({spawn_en, do_retire})
            2'b10:   occ_d = occ_q + 4'd1;
            2'b01:   occ_d = occ_q - 4'd1;
            default: occ_d = occ_q;
        endcase
        wptr_d = wptr_q;
        if (spawn_en) begin
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 4'd1;
        end
        rptr_d = rptr_q;
        if (do_retire) begin
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            occ_q  <= occ_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign occ  = occ_q;
    assign wptr = wptr_q;
    assign rptr = rptr_q;
    assign full = (occ_q == CAP);

endmodule

// File: rtl/arrow_spawn_scheduler.sv
// rtl/arrow_spawn_scheduler.sv - arrow spawn timing, lane selection and slot allocation
// Purpose: counts frames, picks a non-full lane starting from the random preference,
//          issues a spawn request with the lane's next free slot, counts dropped decisions.
// Optional feature macro: DDR_DIFFICULTY_RAMP_EN (score-dependent spawn interval).
// Ports: clk, reset (async, active-high), frame_tick, enable, rand_in[4:0] (LFSR, [1:0]
//        preferred lane), score[10:0], spawn_valid/spawn_lane/spawn_slot/spawn_ready
//        (spawn handshake), retire_valid/retire_lane, lane_occ[15:0] {L,R,D,U},
//        drop_count[7:0] (saturating).
module arrow_spawn_scheduler #(
    parameter int MAX_ARROWS    = ddr_pkg::MAX_ARROWS,
    parameter int BASE_INTERVAL = 200,
    parameter int MIN_INTERVAL  = 40,
    parameter int RAMP_SHIFT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [4:0]  rand_in,
    input  logic [10:0] score,
    output logic        spawn_valid,
    output logic [1:0]  spawn_lane,
    output logic [3:0]  spawn_slot,
    input  logic        spawn_ready,
    input  logic        retire_valid,
    input  logic [1:0]  retire_lane,
    output logic [15:0] lane_occ,
    output logic [7:0]  drop_count
);
    import ddr_pkg::*;

    state_t            state_q, state_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic [7:0]        interval_q, interval_d;
    logic [1:0]        lane_q, lane_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              valid_q, valid_d;
    logic [7:0]        drop_q, drop_d;

    logic [SLOT_W-1:0] occ_w  [4];
    logic [SLOT_W-1:0] wptr_w [4];
    logic [SLOT_W-1:0] rptr_w [4];
    logic [3:0]        full_w;
    logic [3:0]        spawn_en;
    logic [3:0]        retire_en;

    logic [7:0]        next_interval;
    logic [7:0]        tick_inc;
    logic              pick_found;
    logic [1:0]        pick_lane;
    logic [1:0]        cand_lane;
    logic              unused_ok;

`ifdef DDR_DIFFICULTY_RAMP_EN
    logic [11:0] score_sh;
    logic [11:0] ramp_sub;
    always_comb begin
        score_sh = 12'(score) >> RAMP_SHIFT;
        ramp_sub = 12'(BASE_INTERVAL) - score_sh;
        // Underflow (score_sh > BASE) or a result below the floor both clamp.
        if ((score_sh > 12'(BASE_INTERVAL)) || (ramp_sub < 12'(MIN_INTERVAL))) begin
            next_interval = 8'(MIN_INTERVAL);
        end else begin
            next_interval = ramp_sub[7:0];
        end
    end
    assign unused_ok = ^rand_in[4:2];
`else
    assign next_interval = 8'(BASE_INTERVAL);
    assign unused_ok     = ^{rand_in[4:2], score};
`endif

    assign tick_inc = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;

    // First non-full lane in rotation order from the preferred lane; scanning
    // backwards lets the earliest candidate overwrite later ones.
    always_comb begin
        pick_found = 1'b0;
        pick_lane  = rand_in[1:0];
        cand_lane  = rand_in[1:0];
        for (int i = 3; i >= 0; i--) begin
            cand_lane = lane_add(rand_in[1:0], 2'(i));
            if (!full_w[cand_lane]) begin
                pick_found = 1'b1;
                pick_lane  = cand_lane;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        interval_d = interval_q;
        lane_d     = lane_q;
        slot_d     = slot_q;
        valid_d    = valid_q;
        drop_d     = drop_q;
        spawn_en   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    if ({1'b0, fcnt_q} + 9'd1 >= {1'b0, interval_q}) begin
                        fcnt_d  = '0;
                        state_d = ST_PICK;
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                end
            end
            ST_PICK: begin
                if (frame_tick) fcnt_d = tick_inc;
                if (pick_found) begin
                    lane_d  = pick_lane;
                    slot_d  = wptr_w[pick_lane];
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (frame_tick) fcnt_d = tick_inc;
                if (spawn_ready) begin
                    spawn_en[lane_q] = 1'b1;
                    valid_d          = 1'b0;
                    state_d          = enable ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) interval_d = next_interval;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fcnt_q     <= '0;
            interval_q <= 8'(BASE_INTERVAL);
            lane_q     <= '0;
            slot_q     <= '0;
            valid_q    <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            interval_q <= interval_d;
            lane_q     <= lane_d;
            slot_q     <= slot_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    assign retire_en = retire_valid ? (4'b0001 << retire_lane) : 4'b0000;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        lane_tracker #(.MAX_ARROWS(MAX_ARROWS)) u_trk (
            .clk       (clk),
            .reset     (reset),
            .spawn_en  (spawn_en[g]),
            .retire_en (retire_en[g]),
            .occ       (occ_w[g]),
            .wptr      (wptr_w[g]),
            .rptr      (rptr_w[g]),
            .full      (full_w[g])
        );
    end

    assign spawn_valid = valid_q;
    assign spawn_lane  = lane_q;
    assign spawn_slot  = slot_q;
    assign drop_count  = drop_q;
    assign lane_occ    = {occ_w[3], occ_w[2], occ_w[1], occ_w[0]};

endmodule

// File: tb/tb_arrow_spawn_scheduler.sv
// tb/tb_arrow_spawn_scheduler.sv - directed self-checking bench for arrow_spawn_scheduler
module tb_arrow_spawn_scheduler;
    import ddr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  rand_in = '0;
    logic [10:0] score = '0;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic [3:0]  spawn_slot;
    logic        spawn_ready = 1'b0;
    logic        retire_valid = 1'b0;
    logic [1:0]  retire_lane = '0;
    logic [15:0] lane_occ;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    arrow_spawn_scheduler #(
        .MAX_ARROWS(10), .BASE_INTERVAL(3), .MIN_INTERVAL(1), .RAMP_SHIFT(2)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .rand_in(rand_in), .score(score), .spawn_valid(spawn_valid),
        .spawn_lane(spawn_lane), .spawn_slot(spawn_slot), .spawn_ready(spawn_ready),
        .retire_valid(retire_valid), .retire_lane(retire_lane),
        .lane_occ(lane_occ), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic pulse_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    // Three ticks reach the interval of 3; then watch five cycles for a request.
    task automatic decide(output logic got, output logic [1:0] lane,
                          output logic [3:0] slot, output int lat);
        got = 1'b0; lane = '0; slot = '0; lat = -1;
        repeat (3) pulse_tick();
        for (int i = 0; i < 5; i++) begin
            if (spawn_valid && !got) begin
                got = 1'b1; lane = spawn_lane; slot = spawn_slot; lat = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic retire_one(input logic [1:0] l);
        retire_valid = 1'b1; retire_lane = l;
        @(negedge clk);
        retire_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (spawn_valid !== 1'b0 || spawn_lane !== 2'd0 || spawn_slot !== 4'd0) begin
            errors++; $display("FAIL reset_spawn: got v=%b l=%0d s=%0d, want 0 0 0", spawn_valid, spawn_lane, spawn_slot);
        end
        checks++;
        if (lane_occ !== 16'h0000 || drop_count !== 8'd0) begin
            errors++; $display("FAIL reset_counts: got occ=%h drop=%0d, want 0000 0", lane_occ, drop_count);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d, want IDLE", dut.state_q);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic got; logic [1:0] l; logic [3:0] s; int lat;
        enable = 1'b1; rand_in = 5'd2; spawn_ready = 1'b1;
        @(negedge clk);
        decide(got, l, s, lat);
        checks++;
        if (got !== 1'b1 || l !== 2'd2 || s !== 4'd0) begin
            errors++; $display("FAIL basic_spawn: got v=%b l=%0d s=%0d, want 1 2 0", got, l, s);
        end
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL basic_latency: got %0d, want 1", lat);
        end
        checks++;
        if (lane_occ !== 16'h0100) begin
            errors++; $display("FAIL basic_occ: got %h, want 0100", lane_occ);
        end
    endtask

    task automatic test_hold();
        logic got; logic [1:0] l; logic [3:0] s; int lat;
        rand_in = 5'd3; spawn_ready = 1'b0;
        decide(got, l, s, lat);
        checks++;
        if (got !== 1'b1 || l !== 2'd3 || s !== 4'd0) begin
            errors++; $display("FAIL hold_first: got v=%b l=%0d s=%0d, want 1 3 0", got, l, s);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) enable = 1'b0;
            @(negedge clk);
            checks++;
            if (spawn_valid !== 1'b1 || spawn_lane !== 2'd3 || spawn_slot !== 4'd0) begin
                errors++; $display("FAIL hold_stable[%0d]: got v=%b l=%0d s=%0d, want 1 3 0", i, spawn_valid, spawn_lane, spawn_slot);
            end
        end
        spawn_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (spawn_valid !== 1'b0 || dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL hold_release: got v=%b state=%0d, want 0 IDLE", spawn_valid, dut.state_q);
        end
        checks++;
        if (lane_occ !== 16'h1100) begin
            errors++; $display("FAIL hold_occ: got %h, want 1100", lane_occ);
        end
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_same_cycle();
        logic got; logic [1:0] l; logic [3:0] s; int lat;
        rand_in = 5'd3;
        repeat (3) decide(got, l, s, lat);
        checks++;
        if (lane_occ[15:12] !== 4'd4) begin
            errors++; $display("FAIL same_fill: got occ L=%0d, want 4", lane_occ[15:12]);
        end
        spawn_ready = 1'b0;
        decide(got, l, s, lat);
        checks++;
        if (got !== 1'b1 || l !== 2'd3 || s !== 4'd4) begin
            errors++; $display("FAIL same_req: got v=%b l=%0d s=%0d, want 1 3 4", got, l, s);
        end
        spawn_ready = 1'b1; retire_valid = 1'b1; retire_lane = 2'd3;
        @(negedge clk);
        retire_valid = 1'b0;
        checks++;
        if (lane_occ[15:12] !== 4'd4 || dut.wptr_w[3] !== 4'd5 || dut.rptr_w[3] !== 4'd1) begin
            errors++; $display("FAIL same_cycle: got occ=%0d w=%0d r=%0d, want 4 5 1", lane_occ[15:12], dut.wptr_w[3], dut.rptr_w[3]);
        end
        retire_one(2'd1);
        checks++;
        if (lane_occ[7:4] !== 4'd0 || dut.rptr_w[1] !== 4'd0) begin
            errors++; $display("FAIL retire_empty: got occ=%0d r=%0d, want 0 0", lane_occ[7:4], dut.rptr_w[1]);
        end
        retire_one(2'd2);
        checks++;
        if (lane_occ[11:8] !== 4'd0 || dut.rptr_w[2] !== 4'd1) begin
            errors++; $display("FAIL retire_one: got occ=%0d r=%0d, want 0 1", lane_occ[11:8], dut.rptr_w[2]);
        end
    endtask

    task automatic test_wrap();
        logic got; logic [1:0] l; logic [3:0] s; int lat;
        rand_in = 5'd0;
        for (int k = 0; k < 10; k++) begin
            decide(got, l, s, lat);
            checks++;
            if (got !== 1'b1 || l !== 2'd0 || s !== 4'(k)) begin
                errors++; $display("FAIL wrap_spawn[%0d]: got v=%b l=%0d s=%0d, want 1 0 %0d", k, got, l, s, k);
            end
        end
        checks++;
        if (dut.wptr_w[0] !== 4'd0 || lane_occ[3:0] !== 4'd10) begin
            errors++; $display("FAIL wrap_ptr: got w=%0d occ=%0d, want 0 10", dut.wptr_w[0], lane_occ[3:0]);
        end
    endtask

    task automatic test_full_skip();
        logic got; logic [1:0] l; logic [3:0] s; int lat;
        rand_in = 5'd0;
        decide(got, l, s, lat);
        checks++;
        if (got !== 1'b1 || l !== 2'd1 || s !== 4'd0) begin
            errors++; $display("FAIL skip_spawn: got v=%b l=%0d s=%0d, want 1 1 0", got, l, s);
        end
        checks++;
        if (lane_occ !== 16'h401A) begin
            errors++; $display("FAIL skip_occ: got %h, want 401A", lane_occ);
        end
    endtask

    task automatic test_drop();
        logic got; logic [1:0] l; logic [3:0] s; int lat;
        rand_in = 5'd1;
        repeat (25) decide(got, l, s, lat);
        checks++;
        if (lane_occ !== 16'hAAAA) begin
            errors++; $display("FAIL drop_fill: got %h, want AAAA", lane_occ);
        end
        decide(got, l, s, lat);
        checks++;
        if (got !== 1'b0 || drop_count !== 8'd1) begin
            errors++; $display("FAIL drop_first: got v=%b drop=%0d, want 0 1", got, drop_count);
        end
        repeat (255) decide(got, l, s, lat);
        checks++;
        if (drop_count !== 8'd255 || lane_occ !== 16'hAAAA) begin
            errors++; $display("FAIL drop_sat: got drop=%0d occ=%h, want 255 AAAA", drop_count, lane_occ);
        end
    endtask

    task automatic test_retire_wrap();
        repeat (3) retire_one(2'd0);
        checks++;
        if (dut.rptr_w[0] !== 4'd3 || lane_occ[3:0] !== 4'd7) begin
            errors++; $display("FAIL retire_mid: got r=%0d occ=%0d, want 3 7", dut.rptr_w[0], lane_occ[3:0]);
        end
        repeat (7) retire_one(2'd0);
        checks++;
        if (dut.rptr_w[0] !== 4'd0 || lane_occ[3:0] !== 4'd0) begin
            errors++; $display("FAIL retire_wrap: got r=%0d occ=%0d, want 0 0", dut.rptr_w[0], lane_occ[3:0]);
        end
    endtask

    task automatic test_reset_mid_issue();
        logic got; logic [1:0] l; logic [3:0] s; int lat;
        rand_in = 5'd0; spawn_ready = 1'b0;
        decide(got, l, s, lat);
        checks++;
        if (got !== 1'b1 || l !== 2'd0 || spawn_valid !== 1'b1) begin
            errors++; $display("FAIL mid_req: got v=%b l=%0d now=%b, want 1 0 1", got, l, spawn_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (spawn_valid !== 1'b0 || lane_occ !== 16'h0000 || drop_count !== 8'd0) begin
            errors++; $display("FAIL mid_reset: got v=%b occ=%h drop=%0d, want 0 0000 0", spawn_valid, lane_occ, drop_count);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (dut.state_q !== ST_IDLE || dut.wptr_w[3] !== 4'd0) begin
            errors++; $display("FAIL mid_state: got state=%0d w3=%0d, want IDLE 0", dut.state_q, dut.wptr_w[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_same_cycle();
        test_wrap();
        test_full_skip();
        test_drop();
        test_retire_wrap();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
